// File: rtl/decode_exec_pkg.sv
// Shared opcode/funct constants, ALU select encoding for the decode/execute stage.
// Optional SLT support is selected with the DECODE_SLT_EN macro.
package decode_exec_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_sel_t;

endpackage

// File: rtl/decode_exec_stage_alu_core.sv
// Combinational ALU for the decode/execute stage.
// With DECODE_SLT_EN undefined the SLT select returns 0.
module alu_core
  import decode_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  alu_sel_t        alu_sel_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;
  assign shamt = op2_i[4:0];

  always_comb begin
    result_o = '0;
    case (alu_sel_i)
      ALU_ADD: result_o = op1_i + op2_i;
      ALU_SUB: result_o = op1_i - op2_i;
      ALU_AND: result_o = op1_i & op2_i;
      ALU_OR:  result_o = op1_i | op2_i;
      ALU_XOR: result_o = op1_i ^ op2_i;
      ALU_SLL: result_o = op1_i << shamt;
      ALU_SRL: result_o = op1_i >> shamt;
      ALU_SLT: begin
`ifdef DECODE_SLT_EN
        result_o = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
`else
        result_o = '0;
`endif
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_exec_stage.sv
// Registered decode + execute stage of the RV32 teaching pipeline (1-cycle latency).
// DECODE_SLT_EN enables SLT/SLTI; otherwise funct3=010 decodes as illegal.
module decode_exec_stage
  import decode_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic            mem_load,
  output logic            mem_store,
  output logic [XLEN-1:0] store_data,
  output logic            branch_taken,
  output logic            jump,
  output logic [XLEN-1:0] link_data,
  output logic            illegal
);

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd_fld;

  assign opcode   = inst[6:0];
  assign rd_fld   = inst[11:7];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // funct3/funct7 decode shared by R-type and I-ALU
  alu_sel_t arith_sel;
  logic     arith_ill;

  always_comb begin
    arith_sel = ALU_ADD;
    arith_ill = 1'b0;
    case (f3)
      F3_ADD: arith_sel = (opcode == OP_R && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      F3_SLL: arith_sel = ALU_SLL;
      F3_XOR: arith_sel = ALU_XOR;
      F3_OR:  arith_sel = ALU_OR;
      F3_AND: arith_sel = ALU_AND;
      F3_SR: begin
        if (f7 == F7_BASE) arith_sel = ALU_SRL;
        else               arith_ill = 1'b1;
      end
      F3_SLT: begin
`ifdef DECODE_SLT_EN
        arith_sel = ALU_SLT;
`else
        arith_ill = 1'b1;
`endif
      end
      default: arith_ill = 1'b1;
    endcase
  end

  logic [XLEN-1:0] op1, op2, alu_res;
  alu_sel_t        alu_sel;
  logic            writes_rd, is_load, is_store, is_beq, is_jal, ill;

  always_comb begin
    op1       = rs1_data;
    op2       = rs2_data;
    alu_sel   = ALU_ADD;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_beq    = 1'b0;
    is_jal    = 1'b0;
    ill       = 1'b0;
    case (opcode)
      OP_R: begin
        alu_sel   = arith_sel;
        writes_rd = 1'b1;
        ill       = arith_ill | (f7 != F7_BASE && f7 != F7_ALT);
      end
      OP_IMM: begin
        op2       = imm_i;
        alu_sel   = arith_sel;
        writes_rd = 1'b1;
        ill       = arith_ill;
      end
      OP_LOAD: begin
        op2       = imm_i;
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OP_STORE: begin
        op2      = imm_s;
        is_store = 1'b1;
      end
      OP_BRANCH: begin
        op1    = pc;
        op2    = imm_b;
        is_beq = (f3 == F3_BEQ);
        ill    = (f3 != F3_BEQ);
      end
      OP_JAL: begin
        op1       = pc;
        op2       = imm_j;
        writes_rd = 1'b1;
        is_jal    = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  end

  alu_core #(.XLEN(XLEN)) u_alu (
    .op1_i     (op1),
    .op2_i     (op2),
    .alu_sel_i (alu_sel),
    .result_o  (alu_res)
  );

  logic            valid_d, reg_we_d, load_d, store_d, taken_d, jump_d, ill_d;
  logic [XLEN-1:0] result_d, sdata_d, link_d;
  logic [4:0]      rd_d;

  // an illegal encoding only raises illegal; every side effect is suppressed
  always_comb begin
    valid_d  = 1'b1;
    ill_d    = ill;
    result_d = ill ? '0 : alu_res;
    rd_d     = (writes_rd && !ill) ? rd_fld : 5'd0;
    reg_we_d = writes_rd && !ill && (rd_fld != 5'd0);
    load_d   = is_load && !ill;
    store_d  = is_store && !ill;
    sdata_d  = store_d ? rs2_data : '0;
    taken_d  = is_beq && !ill && (rs1_data == rs2_data);
    jump_d   = is_jal && !ill;
    link_d   = jump_d ? pc + XLEN'(4) : '0;
  end

  logic            valid_q, reg_we_q, load_q, store_q, taken_q, jump_q, ill_q;
  logic [XLEN-1:0] result_q, sdata_q, link_q;
  logic [4:0]      rd_q;

  // reset and bubbles both clear the stage, so reset needs no separate branch
  always_ff @(posedge clk) begin
    if (!rst_n || flush || !in_valid) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      reg_we_q <= 1'b0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      sdata_q  <= '0;
      taken_q  <= 1'b0;
      jump_q   <= 1'b0;
      link_q   <= '0;
      ill_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      reg_we_q <= reg_we_d;
      load_q   <= load_d;
      store_q  <= store_d;
      sdata_q  <= sdata_d;
      taken_q  <= taken_d;
      jump_q   <= jump_d;
      link_q   <= link_d;
      ill_q    <= ill_d;
    end
  end

  assign out_valid    = valid_q;
  assign result       = result_q;
  assign rd           = rd_q;
  assign reg_we       = reg_we_q;
  assign mem_load     = load_q;
  assign mem_store    = store_q;
  assign store_data   = sdata_q;
  assign branch_taken = taken_q;
  assign jump         = jump_q;
  assign link_data    = link_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_decode_exec_stage.sv
// Bench for decode_exec_stage: directed cases plus randomized traffic against a reference model.
module tb_decode_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush;
  logic [31:0] inst, pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic        out_valid, reg_we, mem_load, mem_store, branch_taken, jump, illegal;
  logic [31:0] result, store_data, link_data;

  always #5 clk = ~clk;

  decode_exec_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
    .inst(inst), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid),
    .result(result), .rd(rd), .reg_we(reg_we), .mem_load(mem_load),
    .mem_store(mem_store), .store_data(store_data), .branch_taken(branch_taken),
    .jump(jump), .link_data(link_data), .illegal(illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we, ld, st;
    logic [31:0] sdata;
    logic        br, jmp;
    logic [31:0] link;
    logic        ill;
  } obs_t;

  obs_t act;
  assign act = {out_valid, result, rd, reg_we, mem_load, mem_store, store_data,
                branch_taken, jump, link_data, illegal};

  int passed = 0;
  int total  = 0;

  function automatic obs_t mk(logic v, logic [31:0] res, logic [4:0] d, logic we, logic ld,
                              logic st, logic [31:0] sd, logic br, logic jmp,
                              logic [31:0] lk, logic il);
    obs_t o;
    o.valid = v; o.result = res; o.rd = d; o.we = we; o.ld = ld; o.st = st;
    o.sdata = sd; o.br = br; o.jmp = jmp; o.link = lk; o.ill = il;
    return o;
  endfunction

  // Reference: immediates rebuilt as unsigned field value minus the sign weight
  function automatic obs_t model(logic [31:0] w, logic [31:0] p, logic [31:0] a, logic [31:0] b);
    obs_t        o;
    logic [31:0] x, y, vi, vs, vb, vj;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    string       op;
    bit          writes, bad;
    o = '0; o.valid = 1'b1;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    vi = 32'(w[30:20]);                   if (w[31]) vi -= 32'd2048;
    vs = 32'({w[30:25], w[11:7]});        if (w[31]) vs -= 32'd2048;
    vb = 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
    if (w[31]) vb -= 32'd4096;
    vj = 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
    if (w[31]) vj -= 32'd1048576;
    op = "add"; x = a; y = b; writes = 0; bad = 0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      writes = 1;
      if (opc == 7'b0010011) y = vi;
      if (opc == 7'b0110011 && f7 != 7'd0 && f7 != 7'd32) bad = 1;
      case (f3)
        3'd0: op = (opc == 7'b0110011 && f7 == 7'd32) ? "sub" : "add";
        3'd1: op = "sll";
`ifdef DECODE_SLT_EN
        3'd2: op = "slt";
`else
        3'd2: bad = 1;
`endif
        3'd3: bad = 1;
        3'd4: op = "xor";
        3'd5: if (f7 == 7'd0) op = "srl"; else bad = 1;
        3'd6: op = "or";
        default: op = "and";
      endcase
    end else if (opc == 7'b0000011) begin
      writes = 1; y = vi; o.ld = 1;
    end else if (opc == 7'b0100011) begin
      y = vs; o.st = 1; o.sdata = b;
    end else if (opc == 7'b1100011) begin
      x = p; y = vb;
      if (f3 != 3'd0) bad = 1; else o.br = (a == b);
    end else if (opc == 7'b1101111) begin
      writes = 1; x = p; y = vj; o.jmp = 1; o.link = p + 32'd4;
    end else bad = 1;
    if (bad) return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    case (op)
      "add": o.result = x + y;
      "sub": o.result = x - y;
      "sll": o.result = x << y[4:0];
      "srl": o.result = x >> y[4:0];
      "slt": o.result = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      "xor": o.result = x ^ y;
      "or":  o.result = x | y;
      default: o.result = x & y;
    endcase
    if (writes) begin
      o.rd = w[11:7];
      o.we = (w[11:7] != 5'd0);
    end
    return o;
  endfunction

  task automatic apply(logic [31:0] w, logic [31:0] p, logic [31:0] a, logic [31:0] b);
    inst = w; pc = p; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; flush = 0;
    apply(32'h002081B3, 0, 5, 7);
    total++;
    if (act !== obs_t'('0)) $display("FAIL reset_state: got %h want %h", act, obs_t'('0));
    else passed++;
    rst_n = 1;
  endtask

  task automatic test_regaddr();
    inst = 32'h00512623; #1;
    total++;
    if ({rs1_addr, rs2_addr} !== {5'd2, 5'd5})
      $display("FAIL reg_addr: got %0d/%0d want 2/5", rs1_addr, rs2_addr);
    else passed++;
  endtask

  task automatic test_alu();
    obs_t e;
    apply(32'h002081B3, 0, 5, 7);
    e = mk(1, 12, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    total++; if (act !== e) $display("FAIL add: got %h want %h", act, e); else passed++;
    apply(32'h402081B3, 0, 5, 7);
    e = mk(1, 32'hFFFFFFFE, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    total++; if (act !== e) $display("FAIL sub: got %h want %h", act, e); else passed++;
    apply(32'hFFF00093, 0, 0, 32'h55);
    e = mk(1, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    total++; if (act !== e) $display("FAIL addi: got %h want %h", act, e); else passed++;
    // ADD into x0 still computes but must not write
    apply(32'h00208033, 0, 5, 7);
    e = mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (act !== e) $display("FAIL add_x0: got %h want %h", act, e); else passed++;
  endtask

  task automatic test_mem();
    obs_t e;
    apply(32'h00812283, 0, 32'h100, 32'h1234);
    e = mk(1, 32'h108, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    total++; if (act !== e) $display("FAIL lw: got %h want %h", act, e); else passed++;
    apply(32'h00512623, 0, 32'h100, 32'hDEAD);
    e = mk(1, 32'h10C, 0, 0, 0, 1, 32'hDEAD, 0, 0, 0, 0);
    total++; if (act !== e) $display("FAIL sw: got %h want %h", act, e); else passed++;
  endtask

  task automatic test_branch();
    obs_t e;
    apply(32'h00208463, 32'h40, 3, 3);
    e = mk(1, 32'h48, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    total++; if (act !== e) $display("FAIL beq_taken: got %h want %h", act, e); else passed++;
    apply(32'h00208463, 32'h40, 3, 4);
    e = mk(1, 32'h48, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (act !== e) $display("FAIL beq_not_taken: got %h want %h", act, e); else passed++;
  endtask

  task automatic test_jal();
    obs_t e;
    apply(32'h010000EF, 32'h40, 9, 9);
    e = mk(1, 32'h50, 1, 1, 0, 0, 0, 0, 1, 32'h44, 0);
    total++; if (act !== e) $display("FAIL jal: got %h want %h", act, e); else passed++;
  endtask

  task automatic test_illegal();
    obs_t e;
    e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(32'h0000007F, 0, 1, 2);
    total++; if (act !== e) $display("FAIL illegal_opcode: got %h want %h", act, e); else passed++;
    apply(32'h4020D1B3, 0, 1, 2); // SRA
    total++; if (act !== e) $display("FAIL illegal_sra: got %h want %h", act, e); else passed++;
    apply(32'h00209463, 32'h40, 3, 3); // BNE
    total++; if (act !== e) $display("FAIL illegal_bne: got %h want %h", act, e); else passed++;
  endtask

  task automatic test_flush();
    flush = 1;
    apply(32'h002081B3, 0, 5, 7);
    total++;
    if (act !== obs_t'('0)) $display("FAIL flush: got %h want %h", act, obs_t'('0));
    else passed++;
    flush = 0;
    apply(32'h002081B3, 0, 5, 7);
    rst_n = 0;
    apply(32'h002081B3, 0, 5, 7);
    total++;
    if (act !== obs_t'('0)) $display("FAIL reset_midstream: got %h want %h", act, obs_t'('0));
    else passed++;
    rst_n = 1; in_valid = 0;
    apply(32'h002081B3, 0, 5, 7);
    total++;
    if (act !== obs_t'('0)) $display("FAIL invalid_bubble: got %h want %h", act, obs_t'('0));
    else passed++;
    in_valid = 1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 7);
    case (k)
      0: begin
        w[6:0] = 7'b0110011;
        case ($urandom_range(0, 3))
          0, 1: w[31:25] = 7'd0;
          2:    w[31:25] = (w[14:12] == 3'd0 || w[14:12] == 3'd5) ? 7'd32 : 7'd0;
          default: ;
        endcase
      end
      1, 2: begin
        w[6:0] = 7'b0010011;
        if (w[14:12] == 3'd5) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'd32;
      end
      3: w[6:0] = 7'b0000011;
      4: w[6:0] = 7'b0100011;
      5: begin
        w[6:0] = 7'b1100011;
        if ($urandom_range(0, 9) < 7) w[14:12] = 3'd0;
      end
      6: w[6:0] = 7'b1101111;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_random();
    obs_t        e;
    logic [31:0] w, p, a, b;
    for (int n = 0; n < 600; n++) begin
      w = rand_inst(); p = $urandom; a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      in_valid = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      e = (in_valid && !flush) ? model(w, p, a, b) : obs_t'('0);
      apply(w, p, a, b);
      total++;
      if (act !== e) $display("FAIL random[%0d] inst=%h: got %h want %h", n, w, act, e);
      else passed++;
    end
    in_valid = 1; flush = 0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; flush = 0;
    inst = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    test_reset();
    test_regaddr();
    test_alu();
    test_mem();
    test_branch();
    test_jal();
    test_illegal();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_exec_stage.md
Name: decode_exec_stage

Overview:
- Registered decode and execute stage for the 5-stage RV32 teaching pipeline.
- Splits the incoming instruction into fields and generates control (register write, load, store, branch, jump, ALU select).
- Builds sign-extended immediates, selects ALU operands and computes the result, branch decision and link address.
- All results are registered; output latency is one cycle.

Parameters:
- XLEN, 32, datapath width. Only 32 is required to work.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  inst/pc/operand data are valid this cycle
- flush  in  1  squash: the next registered output is a bubble
- inst  in  32  instruction word
- pc  in  32  address of inst
- rs1_addr  out  5  combinational inst[19:15], drives register-file read
- rs2_addr  out  5  combinational inst[24:20]
- rs1_data  in  32  register-file read data for rs1_addr, same cycle
- rs2_data  in  32  register-file read data for rs2_addr, same cycle
- out_valid  out  1  registered outputs hold an instruction
- result  out  32  ALU result: arithmetic value, memory address, or branch/jump target
- rd  out  5  destination register
- reg_we  out  1  write rd at write-back
- mem_load  out  1  load; write-back data comes from memory
- mem_store  out  1  store
- store_data  out  32  rs2_data latched for stores
- branch_taken  out  1  BEQ taken; result is the target
- jump  out  1  JAL; result is the target
- link_data  out  32  pc+4 for JAL, else 0
- illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst_n=0 at posedge): every registered output is 0. Reset has priority over flush, and flush has priority over in_valid.
- Bubble (flush=1 or in_valid=0): all registered outputs are 0 at the next edge.
- Supported opcodes:
  - 0110011 R-type: operands rs1_data, rs2_data.
  - 0010011 I-ALU: rs1_data, sext(inst[31:20]).
  - 0000011 load: rs1_data, sext(inst[31:20]); ALU op ADD.
  - 0100011 store: rs1_data, sext({inst[31:25],inst[11:7]}); ADD.
  - 1100011 BEQ, funct3=000 only: pc, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); ADD.
  - 1101111 JAL: pc, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); ADD.
- ALU select (3 bits): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT.
- funct3 mapping for R-type and I-ALU:
  - 000 → ADD; SUB only when R-type and funct7=0100000.
  - 001 → SLL; 100 → XOR; 101 with funct7=0 → SRL; 110 → OR; 111 → AND; 010 → SLT.
  - 011 and SRA (funct7=0100000 with 101) are illegal.
  - R-type funct7 other than 0000000/0100000 is illegal.
- Shift amount is operand2[4:0]. Arithmetic wraps modulo 2^32. SLT is a signed compare yielding 1 or 0.
- reg_we=1 for R, I-ALU, load and JAL, forced to 0 when rd=0.
- mem_load=1 only for load; mem_store=1 only for store.
- store_data = rs2_data for stores, 0 otherwise.
- branch_taken = BEQ and rs1_data==rs2_data. Not-taken BEQ still reports result and has out_valid=1.
- Illegal encoding: out_valid=1, illegal=1, result=0; reg_we, mem_load, mem_store, branch_taken and jump all 0.

Optional Feature:
- DECODE_SLT_EN.
- Defined: funct3=010 executes SLT/SLTI.
- Undefined: funct3=010 decodes as illegal and ALU code 111 returns 0.

Decomposition:
- Package decode_exec_pkg: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL), alu_sel_t enum, funct3/funct7 constants.
- One combinational sub-module, alu_core: operand1, operand2 and alu_sel in, result out.

Test Plan:
- ADD x3,x1,x2: inst=0x002081B3, rs1_data=5, rs2_data=7 → next cycle result=12, rd=3, reg_we=1, out_valid=1. Same with inst=0x402081B3 (SUB) → result=0xFFFFFFFE.
- ADDI x1,x0,-1: inst=0xFFF00093, rs1_data=0 → result=0xFFFFFFFF, rd=1, reg_we=1.
- LW x5,8(x2): inst=0x00812283, rs1_data=0x100 → result=0x108, mem_load=1, reg_we=1, rd=5. SW x5,12(x2): inst=0x00512623, rs1_data=0x100, rs2_data=0xDEAD → result=0x10C, mem_store=1, store_data=0xDEAD, reg_we=0.
- BEQ x1,x2,+8: inst=0x00208463, pc=0x40, rs1_data=rs2_data=3 → branch_taken=1, result=0x48. Same with rs2_data=4 → branch_taken=0, result=0x48.
- JAL x1,+16: inst=0x010000EF, pc=0x40 → jump=1, result=0x50, link_data=0x44, reg_we=1, rd=1.
- ADD presented with flush=1, then rst_n=0 mid-stream → all outputs 0 at the next edge. Illegal inst=0x0000007F → illegal=1, out_valid=1, reg_we=0.
